decoupled_demux: RTL and testbench
==================================

Name: decoupled_demux

Overview:
Routes one ready/valid input stream to one of N ready/valid output lanes, selected by a per-beat destination field. It is the fan-out counterpart of the priority arbiter, and is used where a shared channel must be split back into per-client streams. Each lane has a one-entry output register, giving 1-cycle latency and full per-lane throughput.

Parameters:
N, 4, number of output lanes (2..16)
W, 8, data width of each beat in bits
DW, 2, width of io_in_dest; must satisfy 2^DW >= N

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
io_in_valid  input  1  input beat valid
io_in_ready  output  1  block can accept the input beat
io_in_bits  input  W  input data
io_in_dest  input  DW  destination lane index
io_out_valid  output  N  bit k is lane k valid
io_out_ready  input  N  bit k is lane k ready
io_out_bits  output  N*W  lane k data in bits [k*W+W-1 : k*W]
io_err  output  1  sticky flag: a beat with dest >= N was dropped
io_err_clr  input  1  clears io_err
io_busy  output  1  OR of all lane valids

Behaviour:
- State per lane k:
  - vq[k]: 1 bit
  - dq[k]: W bits
- Global state: err, 1 bit.
- Reset, asynchronous while reset=1:
  - vq=0, dq=0, err=0.
  - Outputs therefore reset to io_out_valid=0, io_out_bits=0, io_err=0, io_busy=0.
  - io_in_ready is combinational and reads 1 during reset.
- Outputs:
  - io_out_valid[k] = vq[k]; lane-k slice of io_out_bits = dq[k].
  - Both are driven purely from registers.
- io_in_ready:
  - If io_in_dest >= N: 1.
  - Otherwise: !vq[dest] | io_out_ready[dest].
  - Depends only on dest, vq and io_out_ready, never on io_in_valid. The combinational path from io_out_ready to io_in_ready is intended.
- Input accept = io_in_valid & io_in_ready.
  - Valid dest: on the next edge, vq[dest]<=1 and dq[dest]<=io_in_bits.
  - dest >= N: the beat is consumed and discarded, err<=1, and no lane changes.
- Lane drain: io_out_valid[k] & io_out_ready[k]. On the next edge vq[k]<=0, unless the same cycle accepts into lane k.
- Accept and drain on the same lane in the same cycle: vq stays 1 and dq takes the new data. This sustains 1 beat/cycle per lane.
- Lane full and not ready: io_in_ready=0 for that dest; the held lane data is unchanged.
- Lane isolation:
  - A blocked lane stalls only beats addressed to it.
  - Beats to other lanes proceed when the input dest changes.
  - There is no reordering within a lane.
- Input stalls: the block places no requirement that the sender hold dest/bits stable while stalled. Each cycle is evaluated independently.
- io_err:
  - Set on a dropped beat.
  - Cleared when io_err_clr=1.
  - Set has priority over clear in the same cycle.
- io_busy = |vq.
- Latency: a beat accepted in cycle t appears on its lane in cycle t+1.
- Reset asserted mid-transfer: all held beats are discarded immediately. After release the block accepts new beats on the first edge.

Optional Feature:
DEMUX_COUNT_EN
- Defined:
  - Adds output port io_count, width N*16.
  - Lane k slice holds the number of beats delivered on lane k (out_valid & out_ready).
  - Counts increment by 1 per delivery and wrap from 0xFFFF to 0x0000.
  - Counters reset to 0 with reset; there is no other clear.
- Not defined: io_count and the counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then one beat: hold reset 3 cycles, then release with all io_out_ready=0.
   - During reset: io_out_valid=0000, io_busy=0, io_err=0, io_in_ready=1.
   - Then send bits=0xA5, dest=2: next cycle io_out_valid=0100 and lane-2 bits=0xA5.
2. Full-lane backpressure: lane 2 holds 0xA5 with ready=0; present bits=0x3C, dest=2.
   - io_in_ready=0 and lane 2 keeps 0xA5.
   - Assert io_out_ready[2]=1 in the same cycle: io_in_ready=1; next cycle lane 2=0x3C, vq[2]=1.
3. Streaming: io_out_ready=1111; send 0x00..0x07 back-to-back with dest=1.
   - io_in_ready stays 1 throughout.
   - Lane 1 shows 0x00..0x07 on consecutive cycles, one cycle after each input.
4. Lane isolation: lane 0 full with ready[0]=0; send 0x11 to dest=3.
   - Accepted, lane 3=0x11, lane 0 unchanged.
   - A following beat to dest=0 stalls.
5. Bad dest: N=3, DW=2; send 0x77 with dest=3.
   - io_in_ready=1, no lane goes valid, io_err=1 next cycle.
   - Pulse io_err_clr: io_err=0.
   - Bad beat and io_err_clr in the same cycle: io_err=1.
6. Counters (DEMUX_COUNT_EN): deliver 5 beats on lane 0 and 65537 beats on lane 1.
   - io_count lane 0 = 5; lane 1 = 1 after wrap.
   - Mid-stream reset returns all counts and io_busy to 0.

Source files
------------

// File: rtl/decoupled_demux_if.sv
// Ready/valid bundle for decoupled_demux: one input stream, N output lanes, error/busy status.
// io_count exists only when DEMUX_COUNT_EN is defined.
interface decoupled_demux_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int DW = 2
);
  logic            io_in_valid;
  logic            io_in_ready;
  logic [W-1:0]    io_in_bits;
  logic [DW-1:0]   io_in_dest;
  logic [N-1:0]    io_out_valid;
  logic [N-1:0]    io_out_ready;
  logic [N*W-1:0]  io_out_bits;
  logic            io_err;
  logic            io_err_clr;
  logic            io_busy;
`ifdef DEMUX_COUNT_EN
  logic [N*16-1:0] io_count;
`endif

  // The demux itself.
  modport slave (
    input  io_in_valid, io_in_bits, io_in_dest, io_out_ready, io_err_clr,
    output io_in_ready, io_out_valid, io_out_bits, io_err, io_busy
`ifdef DEMUX_COUNT_EN
    , output io_count
`endif
  );

  // Whatever drives the input stream and sinks the lanes.
  modport master (
    output io_in_valid, io_in_bits, io_in_dest, io_out_ready, io_err_clr,
    input  io_in_ready, io_out_valid, io_out_bits, io_err, io_busy
`ifdef DEMUX_COUNT_EN
    , input io_count
`endif
  );
endinterface

// File: rtl/decoupled_demux.sv
// One-to-N ready/valid demux with a one-entry register per lane (1-cycle latency, full rate).
// Optional per-lane delivery counters are enabled by defining DEMUX_COUNT_EN.
module decoupled_demux #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int DW = 2
) (
  input logic               clk,
  input logic               reset,
  decoupled_demux_if.slave  bus
);

  logic [N-1:0] valid_q, valid_d;
  logic [W-1:0] data_q [N];
  logic [W-1:0] data_d [N];
  logic         err_q, err_d;

  logic [N-1:0] sel;
  logic [N-1:0] drain;
  logic         dest_ok;
  logic         accept;

  // Out-of-range destinations are always accepted so a bad beat can never wedge the input.
  assign dest_ok = 32'(bus.io_in_dest) < 32'(N);

  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      sel[k] = dest_ok && (bus.io_in_dest == DW'(k));
    end
  end

  assign drain           = valid_q & bus.io_out_ready;
  assign bus.io_in_ready = !dest_ok || |(sel & (~valid_q | bus.io_out_ready));
  assign accept          = bus.io_in_valid && bus.io_in_ready;

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    for (int k = 0; k < N; k++) begin
      data_d[k] = data_q[k];
      if (drain[k]) valid_d[k] = 1'b0;
      if (accept && sel[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = bus.io_in_bits;
      end
    end
    if (bus.io_err_clr)       err_d = 1'b0;
    if (accept && !dest_ok)   err_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all lanes update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < N; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int k = 0; k < N; k++) data_q[k] <= data_d[k];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign bus.io_out_bits[k*W +: W] = data_q[k];
  end

  assign bus.io_out_valid = valid_q;
  assign bus.io_err       = err_q;
  assign bus.io_busy      = |valid_q;

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt_q [N];
  logic [15:0] cnt_d [N];

  // Counters wrap naturally at 16 bits.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = cnt_q[k] + 16'(drain[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_cnt
    assign bus.io_count[k*16 +: 16] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_decoupled_demux.sv
// Directed self-checking bench for decoupled_demux: a 4-lane instance for the main
// behaviour and a 3-lane instance (DW=2) to exercise out-of-range destinations.
module tb_decoupled_demux;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  decoupled_demux_if #(.N(4), .W(8), .DW(2)) bus4 ();
  decoupled_demux_if #(.N(3), .W(8), .DW(2)) bus3 ();

  decoupled_demux #(.N(4), .W(8), .DW(2)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  decoupled_demux #(.N(3), .W(8), .DW(2)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled/driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane4(input int k);
    return bus4.io_out_bits[k*8 +: 8];
  endfunction

  task automatic idle4();
    bus4.io_in_valid = 1'b0;
    bus4.io_in_bits  = '0;
    bus4.io_in_dest  = '0;
    bus4.io_err_clr  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle4();
    bus4.io_out_ready = '0;
    bus3.io_in_valid  = 1'b0;
    bus3.io_in_bits   = '0;
    bus3.io_in_dest   = '0;
    bus3.io_err_clr   = 1'b0;
    bus3.io_out_ready = '0;

    // 1. Reset state, then one beat to lane 2.
    repeat (3) step();
    check("rst_out_valid", 32'(bus4.io_out_valid), 32'h0);
    check("rst_busy",      32'(bus4.io_busy),      32'h0);
    check("rst_err",       32'(bus4.io_err),       32'h0);
    check("rst_in_ready",  32'(bus4.io_in_ready),  32'h1);
    check("rst_out_bits",  32'(bus4.io_out_bits),  32'h0);
    reset = 1'b0;
    step();
    bus4.io_in_valid = 1'b1;
    bus4.io_in_bits  = 8'hA5;
    bus4.io_in_dest  = 2'd2;
    #1 check("t1_in_ready", 32'(bus4.io_in_ready), 32'h1);
    step();
    idle4();
    check("t1_out_valid", 32'(bus4.io_out_valid), 32'b0100);
    check("t1_lane2",     32'(lane4(2)),          32'hA5);
    check("t1_busy",      32'(bus4.io_busy),      32'h1);

    // 2. Full lane backpressure, then same-cycle drain and refill.
    bus4.io_in_valid = 1'b1;
    bus4.io_in_bits  = 8'h3C;
    bus4.io_in_dest  = 2'd2;
    #1 check("t2_blocked_ready", 32'(bus4.io_in_ready), 32'h0);
    step();
    check("t2_lane2_held", 32'(lane4(2)), 32'hA5);
    bus4.io_out_ready = 4'b0100;
    #1 check("t2_pass_ready", 32'(bus4.io_in_ready), 32'h1);
    step();
    idle4();
    bus4.io_out_ready = 4'b0000;
    check("t2_lane2_new",   32'(lane4(2)),          32'h3C);
    check("t2_out_valid",   32'(bus4.io_out_valid), 32'b0100);

    // 3. Streaming eight beats to lane 1 at full rate (lane 2 also drains here).
    bus4.io_out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      bus4.io_in_valid = 1'b1;
      bus4.io_in_dest  = 2'd1;
      bus4.io_in_bits  = 8'(i);
      #1 check($sformatf("t3_ready_%0d", i), 32'(bus4.io_in_ready), 32'h1);
      step();
      check($sformatf("t3_valid_%0d", i), 32'(bus4.io_out_valid[1]), 32'h1);
      check($sformatf("t3_lane1_%0d", i), 32'(lane4(1)), 32'(i));
    end
    idle4();
    step();
    check("t3_drained", 32'(bus4.io_out_valid), 32'h0);
    check("t3_busy",    32'(bus4.io_busy),      32'h0);

    // 4. Lane isolation: lane 0 blocked does not stall lane 3.
    bus4.io_out_ready = 4'b0000;
    bus4.io_in_valid  = 1'b1;
    bus4.io_in_dest   = 2'd0;
    bus4.io_in_bits   = 8'h55;
    step();
    bus4.io_in_dest   = 2'd3;
    bus4.io_in_bits   = 8'h11;
    #1 check("t4_ready_d3", 32'(bus4.io_in_ready), 32'h1);
    step();
    check("t4_lane3",      32'(lane4(3)),          32'h11);
    check("t4_lane0",      32'(lane4(0)),          32'h55);
    check("t4_out_valid",  32'(bus4.io_out_valid), 32'b1001);
    bus4.io_in_dest = 2'd0;
    bus4.io_in_bits = 8'h22;
    #1 check("t4_ready_d0", 32'(bus4.io_in_ready), 32'h0);
    step();
    idle4();
    check("t4_lane0_held", 32'(lane4(0)), 32'h55);

    // 5. Out-of-range destination on the 3-lane instance.
    bus3.io_in_valid = 1'b1;
    bus3.io_in_dest  = 2'd3;
    bus3.io_in_bits  = 8'h77;
    #1 check("t5_bad_ready", 32'(bus3.io_in_ready), 32'h1);
    step();
    bus3.io_in_valid = 1'b0;
    check("t5_no_lane", 32'(bus3.io_out_valid), 32'h0);
    check("t5_err_set", 32'(bus3.io_err),       32'h1);
    bus3.io_err_clr = 1'b1;
    step();
    bus3.io_err_clr = 1'b0;
    check("t5_err_clr", 32'(bus3.io_err), 32'h0);
    bus3.io_in_valid = 1'b1;
    bus3.io_err_clr  = 1'b1;
    step();
    bus3.io_in_valid = 1'b0;
    bus3.io_err_clr  = 1'b0;
    check("t5_set_wins", 32'(bus3.io_err), 32'h1);
    check("t5_main_err", 32'(bus4.io_err), 32'h0);

`ifdef DEMUX_COUNT_EN
    // 6. Delivery counters, including 16-bit wrap, and mid-stream reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_cnt_rst", 32'(bus4.io_count[15:0]), 32'h0);
    bus4.io_out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      bus4.io_in_valid = 1'b1;
      bus4.io_in_dest  = 2'd0;
      bus4.io_in_bits  = 8'(i);
      step();
    end
    for (int i = 0; i < 65537; i++) begin
      bus4.io_in_valid = 1'b1;
      bus4.io_in_dest  = 2'd1;
      bus4.io_in_bits  = 8'(i);
      step();
    end
    idle4();
    step();
    check("t6_cnt_lane0", 32'(bus4.io_count[15:0]),  32'd5);
    check("t6_cnt_lane1", 32'(bus4.io_count[31:16]), 32'd1);
    bus4.io_out_ready = 4'b0000;
    bus4.io_in_valid  = 1'b1;
    bus4.io_in_dest   = 2'd2;
    bus4.io_in_bits   = 8'h9A;
    step();
    idle4();
    check("t6_busy_pre", 32'(bus4.io_busy), 32'h1);
    reset = 1'b1;
    #1;
    check("t6_busy_rst",  32'(bus4.io_busy),  32'h0);
    check("t6_count_rst", 32'(bus4.io_count), 32'h0);
    step();
    reset = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
